// File: rtl/maquina_niveles.sv
// Multi-level game controller: tracks level, lives, hits and score from hit/miss pulses,
// and drives start/restart/stop strobes with a level-up pause and a win state.
module maquina_niveles #(
  parameter int NUM_LEVELS     = 4,
  parameter int HITS_PER_LEVEL = 16,
  parameter int LIVES          = 3,
  parameter int LEVELUP_CYCLES = 8,
  parameter int SCORE_W        = 12,
  localparam int NIV_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  localparam int VID_W = $clog2(LIVES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               iniciar,
  input  logic               acierto,
  input  logic               fallo,
  output logic               comenzar,
  output logic               reiniciar,
  output logic               stop,
  output logic               gano,
  output logic [NIV_W-1:0]   nivel,
  output logic [VID_W-1:0]   vidas,
  output logic [SCORE_W-1:0] puntaje
);

  localparam int HIT_W = $clog2(HITS_PER_LEVEL + 1);
  localparam int CNT_W = (LEVELUP_CYCLES > 1) ? $clog2(LEVELUP_CYCLES) : 1;
  localparam int SUM_W = ((SCORE_W > NIV_W) ? SCORE_W : NIV_W) + 2;
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  typedef enum logic [2:0] {
    INICIAL      = 3'd0,
    JUGANDO      = 3'd1,
    CAMBIO_NIVEL = 3'd2,
    PERDIO       = 3'd3,
    GANO         = 3'd4
  } estado_t;

  estado_t            r_estado, w_estado_next;
  logic [NIV_W-1:0]   r_nivel, w_nivel_next;
  logic [VID_W-1:0]   r_vidas, w_vidas_next;
  logic [HIT_W-1:0]   r_hits, w_hits_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [SCORE_W-1:0] r_puntaje, w_puntaje_next;
  logic               r_comenzar, w_comenzar_next;
  logic               r_reiniciar, w_reiniciar_next;
  logic               r_stop, w_stop_next;
  logic               r_gano, w_gano_next;

  logic [SUM_W-1:0]   w_sum;
  logic [SCORE_W-1:0] w_puntaje_sat;
  logic [HIT_W-1:0]   w_hits_inc;

  // Each hit is worth (level index + 1); the wide sum exposes overflow for saturation.
  assign w_sum         = SUM_W'(r_puntaje) + SUM_W'(r_nivel) + SUM_W'(1);
  assign w_puntaje_sat = (w_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : w_sum[SCORE_W-1:0];
  assign w_hits_inc    = r_hits + HIT_W'(1);

  always_comb begin
    w_estado_next    = r_estado;
    w_nivel_next     = r_nivel;
    w_vidas_next     = r_vidas;
    w_hits_next      = r_hits;
    w_cnt_next       = r_cnt;
    w_puntaje_next   = r_puntaje;
    w_comenzar_next  = 1'b0;
    w_reiniciar_next = 1'b0;

    case (r_estado)
      INICIAL, PERDIO, GANO: begin
        if (iniciar) begin
          w_estado_next   = JUGANDO;
          w_nivel_next    = '0;
          w_vidas_next    = VID_W'(LIVES);
          w_hits_next     = '0;
          w_puntaje_next  = '0;
          w_comenzar_next = 1'b1;
        end
      end
      JUGANDO: begin
        // A miss takes priority over a simultaneous hit.
        if (fallo) begin
          w_vidas_next = r_vidas - VID_W'(1);
          if (r_vidas == VID_W'(1)) begin
            w_estado_next    = PERDIO;
            w_reiniciar_next = 1'b1;
          end
        end else if (acierto) begin
          w_hits_next    = w_hits_inc;
          w_puntaje_next = w_puntaje_sat;
          if (w_hits_inc == HIT_W'(HITS_PER_LEVEL)) begin
            if (r_nivel == NIV_W'(NUM_LEVELS - 1)) begin
              w_estado_next = GANO;
            end else begin
              w_estado_next = CAMBIO_NIVEL;
              w_nivel_next  = r_nivel + NIV_W'(1);
              w_hits_next   = '0;
              w_cnt_next    = '0;
            end
          end
        end
      end
      CAMBIO_NIVEL: begin
        if (r_cnt == CNT_W'(LEVELUP_CYCLES - 1)) begin
          w_estado_next = JUGANDO;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: w_estado_next = INICIAL;
    endcase

    w_stop_next = (w_estado_next != JUGANDO);
    w_gano_next = (w_estado_next == GANO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado    <= INICIAL;
      r_nivel     <= '0;
      r_vidas     <= VID_W'(LIVES);
      r_hits      <= '0;
      r_cnt       <= '0;
      r_puntaje   <= '0;
      r_comenzar  <= 1'b0;
      r_reiniciar <= 1'b0;
      r_stop      <= 1'b1;
      r_gano      <= 1'b0;
    end else begin
      r_estado    <= w_estado_next;
      r_nivel     <= w_nivel_next;
      r_vidas     <= w_vidas_next;
      r_hits      <= w_hits_next;
      r_cnt       <= w_cnt_next;
      r_puntaje   <= w_puntaje_next;
      r_comenzar  <= w_comenzar_next;
      r_reiniciar <= w_reiniciar_next;
      r_stop      <= w_stop_next;
      r_gano      <= w_gano_next;
    end
  end

  assign comenzar  = r_comenzar;
  assign reiniciar = r_reiniciar;
  assign stop      = r_stop;
  assign gano      = r_gano;
  assign nivel     = r_nivel;
  assign vidas     = r_vidas;
  assign puntaje   = r_puntaje;

endmodule
